// File: rtl/mode2_round_ctrl_if.sv
// Player inputs and LED/score outputs of one switch-match reaction round.
// The DUT takes the slave side; the driver of the inputs takes the master side.
interface mode2_round_ctrl_if;
  logic        selection;
  logic        key;
  logic        tick;
  logic [7:0]  sw;
  logic [7:0]  light;
  logic        busy;
  logic        result_valid;
  logic [23:0] reaction_time;
  logic [23:0] best_time;
  logic        early;
  logic        timeout;

  modport master (
    output selection, key, tick, sw,
    input  light, busy, result_valid, reaction_time, best_time, early, timeout
  );
  modport slave (
    input  selection, key, tick, sw,
    output light, busy, result_valid, reaction_time, best_time, early, timeout
  );
endinterface

// File: rtl/mode2_round_ctrl.sv
// Reaction-round sequencer: arm on key, random delay, show LED target, time the
// switch match in ticks, publish the result and keep the session best time.
module mode2_round_ctrl #(
  parameter int unsigned DELAY_MIN  = 500,
  parameter int unsigned DELAY_BITS = 11,
  parameter int unsigned TIMEOUT    = 5000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              cin,
  input  logic              reset,
  mode2_round_ctrl_if.slave rnd
);
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHOW, S_RESULT} state_e;

  localparam logic [23:0] NO_TIME     = 24'hFFFFFF;
  localparam logic [23:0] TIMEOUT_C   = 24'(TIMEOUT);
  localparam logic [23:0] DELAY_MIN_C = 24'(DELAY_MIN);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        key_q;
  logic [23:0] delay_cnt_q, delay_cnt_d;
  logic [23:0] react_cnt_q, react_cnt_d;
  logic [7:0]  pattern_q, pattern_d;
  logic [7:0]  light_q, light_d;
  logic        busy_q, busy_d;
  logic        rv_q, rv_d;
  logic [23:0] reaction_q, reaction_d;
  logic [23:0] best_q, best_d;
  logic        early_q, early_d;
  logic        timeout_q, timeout_d;
  logic        key_rise;
  logic        match;
  logic [23:0] delay_ext;

  assign key_rise  = rnd.key & ~key_q;
  assign match     = (rnd.sw == pattern_q);
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign delay_ext = 24'(lfsr_q[DELAY_BITS-1:0]);

  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    react_cnt_d = react_cnt_q;
    pattern_d   = pattern_q;
    reaction_d  = reaction_q;
    best_d      = best_q;
    early_d     = early_q;
    timeout_d   = timeout_q;
    if (!rnd.selection) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_rise) begin
            state_d     = S_DELAY;
            delay_cnt_d = DELAY_MIN_C + delay_ext;
            pattern_d   = (lfsr_q[15:8] == 8'h00) ? 8'h01 : lfsr_q[15:8];
            early_d     = 1'b0;
            timeout_d   = 1'b0;
          end
        end
        S_DELAY: begin
          // A false start takes priority over the terminal delay tick.
          if (key_rise) begin
            early_d    = 1'b1;
            reaction_d = NO_TIME;
            state_d    = S_RESULT;
          end else if (rnd.tick) begin
            delay_cnt_d = delay_cnt_q - 24'd1;
            if (delay_cnt_q == 24'd1) begin
              state_d     = S_SHOW;
              react_cnt_d = '0;
            end
          end
        end
        S_SHOW: begin
          if (match) begin
            state_d = S_RESULT;
            if (react_cnt_q == 24'd0) begin
              early_d    = 1'b1;
              reaction_d = NO_TIME;
            end else begin
              reaction_d = react_cnt_q;
              if (react_cnt_q < best_q) best_d = react_cnt_q;
            end
          end else if (react_cnt_q == TIMEOUT_C) begin
            timeout_d  = 1'b1;
            reaction_d = NO_TIME;
            state_d    = S_RESULT;
          end else if (rnd.tick) begin
            react_cnt_d = react_cnt_q + 24'd1;
          end
        end
        S_RESULT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  assign light_d = (state_d == S_SHOW) ? pattern_d : 8'h00;
  assign busy_d  = (state_d != S_IDLE);
  assign rv_d    = (state_d == S_RESULT);

  always_ff @(posedge cin) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      key_q      <= 1'b1;
      light_q    <= 8'h00;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      reaction_q <= NO_TIME;
      best_q     <= NO_TIME;
      early_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      key_q      <= rnd.key;
      light_q    <= light_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      reaction_q <= reaction_d;
      best_q     <= best_d;
      early_q    <= early_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge cin) begin
    delay_cnt_q <= delay_cnt_d;
    react_cnt_q <= react_cnt_d;
    pattern_q   <= pattern_d;
  end

  assign rnd.light         = light_q;
  assign rnd.busy          = busy_q;
  assign rnd.result_valid  = rv_q;
  assign rnd.reaction_time = reaction_q;
  assign rnd.best_time     = best_q;
  assign rnd.early         = early_q;
  assign rnd.timeout       = timeout_q;
endmodule

// File: doc/mode2_round_ctrl.md
# mode2_round_ctrl

Round sequencer for the switch-match reaction mode. It arms on a key press and waits a pseudo-random delay. It then lights an 8-bit LED target pattern and times, in ticks, how long the player takes to set the switches to that pattern. It publishes the result and maintains the session best time. It replaces the ad-hoc delay/compare/highscore glue with one clocked controller feeding the LED decoder and score display.

## Interface

Clock is `cin`. Reset is `reset`: one clock; reset is synchronous and active-high.

Parameters:
- `DELAY_MIN`, default 500: minimum arm-to-show delay, in ticks.
- `DELAY_BITS`, default 11: width of the random delay extension, 0..2^DELAY_BITS-1 ticks.
- `TIMEOUT`, default 5000: ticks allowed in SHOW before the round fails.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `cin` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `selection` in 1: mode enable. When low, the FSM is forced to IDLE.
- `key` in 1: start/react key, debounced upstream, active-high level.
- `tick` in 1: one-cycle timebase enable, nominally 1 kHz.
- `sw` in 8: player switches.
- `light` out 8: target pattern. Nonzero only in SHOW.
- `busy` out 1: high in DELAY, SHOW and RESULT.
- `result_valid` out 1: one-cycle pulse in RESULT.
- `reaction_time` out 24: last result in ticks. Holds until the next RESULT.
- `best_time` out 24: minimum successful reaction_time.
- `early` out 1: last round was a false start. Held until the next arm.
- `timeout` out 1: last round timed out. Held until the next arm.

## Operation

- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every `cin` cycle regardless of state. Reset to LFSR_SEED.
- `key_rise`: `key` high now and low in the previous cycle. The key history register resets to 1, so a key held through reset does not arm.
- `match`: `sw == pattern_q`.

States:
- IDLE: light=0, busy=0.
  - On key_rise with selection=1: go to DELAY.
  - Load `delay_cnt = DELAY_MIN + lfsr[DELAY_BITS-1:0]`.
  - Latch `pattern_q = lfsr[15:8]`, or 8'h01 if that byte is zero.
  - Clear early and timeout.
- DELAY: on tick, decrement delay_cnt.
  - A tick when delay_cnt==1: go to SHOW, clear react_cnt.
  - key_rise in DELAY: set early, go to RESULT.
- SHOW: light=pattern_q. On tick, react_cnt += 1.
  - match with react_cnt==0 (switches preset before the light): set early, go to RESULT.
  - match with react_cnt>=1: reaction_time=react_cnt, go to RESULT.
  - react_cnt==TIMEOUT without match: set timeout, reaction_time=24'hFFFFFF, go to RESULT.
- RESULT (one cycle): result_valid=1.
  - If neither early nor timeout and reaction_time < best_time: best_time <= reaction_time.
  - Go to IDLE.
- On early, reaction_time=24'hFFFFFF.
- Width rules: react_cnt is 24 bits and never exceeds TIMEOUT. delay_cnt is 24 bits and the sum is unsigned with no overflow at defaults.

Priorities and boundary cases:
- DELAY terminal tick and key_rise in the same cycle: early wins.
- SHOW match and TIMEOUT reached in the same cycle: match wins, and the result is a success with reaction_time=TIMEOUT.
- selection low in any state: next state IDLE, light=0, busy=0. result_valid is not pulsed. reaction_time, best_time, early and timeout hold.
- key_rise in SHOW or RESULT is ignored. Re-arming needs a fresh key_rise in IDLE.
- best_time is cleared only by reset, not by selection.

## Timing

- Reset values:
  - State IDLE.
  - light=0, busy=0, result_valid=0.
  - reaction_time=24'hFFFFFF, best_time=24'hFFFFFF.
  - early=0, timeout=0.
  - lfsr=LFSR_SEED.
- All outputs are registered.
- IDLE→DELAY: busy rises 1 cycle after the `cin` edge sampling key_rise.
- The light is valid in the first SHOW cycle, i.e. the cycle after the terminal tick is sampled.
- result_valid and the updated reaction_time/best_time appear 1 cycle after the match/timeout/early condition is sampled. best_time and reaction_time update on the same edge.
- Arm-to-light delay is DELAY_MIN..DELAY_MIN+2^DELAY_BITS-1 ticks, with ±1 tick phase uncertainty.
- reset asserted mid-round returns to the reset values on the next edge.

## Test plan

- Reset, then selection=1, key pulse, no early key. Release the key, keep sw off-target, and after light≠0 wait 37 ticks before driving sw=light. Expect result_valid pulse, reaction_time=37, best_time=37, early=0.
- Second round with a 52-tick reaction. Expect reaction_time=52, best_time stays 37. Third round with a 20-tick reaction: best_time=20.
- key_rise 10 ticks after arm (during DELAY). Expect early=1, reaction_time=24'hFFFFFF, light never nonzero, best_time unchanged.
- Never match in SHOW. Expect timeout=1 after exactly TIMEOUT ticks of light, result_valid once, reaction_time=24'hFFFFFF.
- Preset sw to the pattern predicted from the LFSR before the show. Expect early=1 in the first SHOW cycle.
- Drop selection mid-SHOW. Expect light=0 and busy=0 next cycle and no result_valid. Then assert reset: best_time=24'hFFFFFF and lfsr=LFSR_SEED.
